// File: rtl/if_fetch_buf_stage.sv
// if_fetch_buf_stage: instruction-fetch stage for the 5-stage LoongArch pipeline.
// Issues SRAM-like fetch requests with up to MAX_OUTST requests in flight.
// Returned instructions wait in an IBUF_DEPTH-entry buffer ahead of ID.
// On an exception, ertn or branch redirect, responses to stale requests are counted and dropped.
// Optional feature macro: IF_ADEF_EN. When it is defined, a misaligned fetch PC raises an
// address-error entry (adef bit on the bus) instead of issuing a request.
module if_fetch_buf_stage #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          IBUF_DEPTH = 4,
  parameter int          MAX_OUTST  = 2,
`ifdef IF_ADEF_EN
  parameter int          IF_ID_W    = 65
`else
  parameter int          IF_ID_W    = 64
`endif
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               id_allowin,
  output logic               if_id_valid,
  output logic [IF_ID_W-1:0] if_id_bus,
  input  logic [32:0]        id_if_bus,
  input  logic               wb_ex,
  input  logic [31:0]        ex_entry,
  input  logic               ertn_flush,
  input  logic [31:0]        ertn_entry,
  output logic               inst_sram_req,
  output logic               inst_sram_wr,
  output logic [1:0]         inst_sram_size,
  output logic [31:0]        inst_sram_addr,
  output logic [3:0]         inst_sram_wstrb,
  output logic [31:0]        inst_sram_wdata,
  input  logic               inst_sram_addr_ok,
  input  logic               inst_sram_data_ok,
  input  logic [31:0]        inst_sram_rdata
);

  localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IBUF_DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTST);

  logic [31:0]        r_fetchPc;
  logic [IF_ID_W-1:0] r_ibuf [IBUF_DEPTH];
  logic [31:0]        r_tag  [IBUF_DEPTH];
  logic [PW-1:0]      r_ibufRd;
  logic [PW-1:0]      r_ibufWr;
  logic [PW-1:0]      r_tagRd;
  logic [PW-1:0]      r_tagWr;
  logic [CW-1:0]      r_ibufCnt;
  logic [CW-1:0]      r_outst;
  logic [CW-1:0]      r_discard;
  logic               r_started;

  logic               w_brTaken;
  logic [31:0]        w_brTarget;
  logic               w_redirect;
  logic [31:0]        w_target;
  logic [CW-1:0]      w_reserved;
  logic               w_alignOk;
  logic               w_req;
  logic               w_addrHs;
  logic               w_dataValid;
  logic               w_dropData;
  logic               w_keepData;
  logic               w_ifIdValid;
  logic               w_pop;
  logic               w_push;
  logic [IF_ID_W-1:0] w_pushEntry;
  logic [31:0]        w_fetchAddr;

  assign {w_brTaken, w_brTarget} = id_if_bus;
  assign w_redirect  = wb_ex | ertn_flush | w_brTaken;
  assign w_target    = wb_ex ? ex_entry : (ertn_flush ? ertn_entry : w_brTarget);
  assign w_fetchAddr = {r_fetchPc[31:2], 2'b00};

  // Slots already promised to the buffer: buffered entries plus live (non-discarded) requests.
  assign w_reserved = r_ibufCnt + r_outst - r_discard;

`ifdef IF_ADEF_EN
  logic r_adefDone;
  logic w_adefPush;
  assign w_alignOk  = (r_fetchPc[1:0] == 2'b00);
  assign w_adefPush = r_started & ~r_adefDone & ~w_alignOk & (r_outst == '0) &
                      (r_ibufCnt < DEPTH_C);
  assign w_push      = w_keepData | w_adefPush;
  assign w_pushEntry = w_adefPush ? {1'b1, r_fetchPc, 32'h0}
                                  : {1'b0, r_tag[r_tagRd], inst_sram_rdata};
`else
  assign w_alignOk   = 1'b1;
  assign w_push      = w_keepData;
  assign w_pushEntry = {r_tag[r_tagRd], inst_sram_rdata};
`endif

  assign w_req = resetn & r_started & ~w_redirect & w_alignOk &
                 (r_outst < MAXO_C) & (w_reserved < DEPTH_C);
  assign w_addrHs    = w_req & inst_sram_addr_ok;
  assign w_dataValid = inst_sram_data_ok & (r_outst != '0);
  assign w_dropData  = w_dataValid & (r_discard != '0);
  assign w_keepData  = w_dataValid & (r_discard == '0);
  assign w_ifIdValid = resetn & (r_ibufCnt != '0) & ~wb_ex & ~ertn_flush;
  assign w_pop       = w_ifIdValid & id_allowin & ~w_redirect;

  assign inst_sram_req   = w_req;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_addr  = w_fetchAddr;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign if_id_valid     = w_ifIdValid;
  assign if_id_bus       = r_ibuf[r_ibufRd];

  // Storage arrays: PC tags of accepted requests and buffered {pc, inst} entries.
  always_ff @(posedge clk) begin
    if (w_addrHs) begin
      r_tag[r_tagWr] <= w_fetchAddr;
    end
    if (w_push && !w_redirect) begin
      r_ibuf[r_ibufWr] <= w_pushEntry;
    end
  end

  // Fetch PC, FIFO pointers and the outstanding/discard counters; a redirect flushes everything.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_fetchPc  <= RESET_PC;
      r_ibufRd   <= '0;
      r_ibufWr   <= '0;
      r_tagRd    <= '0;
      r_tagWr    <= '0;
      r_ibufCnt  <= '0;
      r_outst    <= '0;
      r_discard  <= '0;
      r_started  <= 1'b0;
`ifdef IF_ADEF_EN
      r_adefDone <= 1'b0;
`endif
    end else begin
      r_started <= 1'b1;
      if (w_redirect) begin
        r_fetchPc  <= w_target;
        r_ibufRd   <= '0;
        r_ibufWr   <= '0;
        r_tagRd    <= '0;
        r_tagWr    <= '0;
        r_ibufCnt  <= '0;
        r_outst    <= r_outst - CW'(w_dataValid);
        r_discard  <= r_outst - CW'(w_dataValid);
`ifdef IF_ADEF_EN
        r_adefDone <= 1'b0;
`endif
      end else begin
        if (w_addrHs) begin
          r_fetchPc <= r_fetchPc + 32'd4;
          r_tagWr   <= r_tagWr + PW'(1);
        end
        if (w_keepData) begin
          r_tagRd <= r_tagRd + PW'(1);
        end
        if (w_push) begin
          r_ibufWr <= r_ibufWr + PW'(1);
        end
        if (w_pop) begin
          r_ibufRd <= r_ibufRd + PW'(1);
        end
        r_ibufCnt <= r_ibufCnt + CW'(w_push) - CW'(w_pop);
        r_outst   <= r_outst + CW'(w_addrHs) - CW'(w_dataValid);
        r_discard <= r_discard - CW'(w_dropData);
`ifdef IF_ADEF_EN
        if (w_adefPush) begin
          r_adefDone <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_buf_stage.sv
// tb_if_fetch_buf_stage: scoreboard bench for if_fetch_buf_stage.
// A small memory responder returns instructions for accepted addresses; the bench keeps its own
// fetch-PC model and a queue of entries that ID should see, in order.
module tb_if_fetch_buf_stage;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
`ifdef IF_ADEF_EN
  localparam int BW = 65;
`else
  localparam int BW = 64;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          id_allowin;
  logic          if_id_valid;
  logic [BW-1:0] if_id_bus;
  logic [32:0]   id_if_bus;
  logic          wb_ex;
  logic [31:0]   ex_entry;
  logic          ertn_flush;
  logic [31:0]   ertn_entry;
  logic          inst_sram_req;
  logic          inst_sram_wr;
  logic [1:0]    inst_sram_size;
  logic [31:0]   inst_sram_addr;
  logic [3:0]    inst_sram_wstrb;
  logic [31:0]   inst_sram_wdata;
  logic          inst_sram_addr_ok;
  logic          inst_sram_data_ok;
  logic [31:0]   inst_sram_rdata;

  int            testCount = 0;
  int            failCount = 0;
  logic [31:0]   expPc;
  logic [BW-1:0] expQ[$];
  logic [31:0]   pending[$];
  logic          obsReq;
  logic          obsValid;
  logic [BW-1:0] obsBus;
  logic [31:0]   obsAddr;

  if_fetch_buf_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .id_allowin        (id_allowin),
    .if_id_valid       (if_id_valid),
    .if_id_bus         (if_id_bus),
    .id_if_bus         (id_if_bus),
    .wb_ex             (wb_ex),
    .ex_entry          (ex_entry),
    .ertn_flush        (ertn_flush),
    .ertn_entry        (ertn_entry),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Instruction word the memory holds at a given address
  function automatic logic [31:0] instOf(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]};
  endfunction

  function automatic logic [BW-1:0] mkEntry(input logic adef, input logic [31:0] pc,
                                            input logic [31:0] inst);
    return BW'({adef, pc, inst});
  endfunction

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [64:0] observed,
                             input logic [64:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock window: drive at negedge, sample 1 unit later, advance the model for the next edge
  task automatic applyStimulus(input logic rstn, input logic aok, input logic dEn,
                               input logic allow, input logic wb, input logic [31:0] wbT,
                               input logic er, input logic [31:0] erT,
                               input logic br, input logic [31:0] brT);
    logic          redirect;
    logic [31:0]   tgt;
    logic [BW-1:0] expEntry;
    @(negedge clk);
    resetn            = rstn;
    inst_sram_addr_ok = aok;
    inst_sram_data_ok = dEn && (pending.size() != 0);
    inst_sram_rdata   = inst_sram_data_ok ? instOf(pending[0]) : 32'hdeadbeef;
    id_allowin        = allow;
    wb_ex             = wb;
    ex_entry          = wbT;
    ertn_flush        = er;
    ertn_entry        = erT;
    id_if_bus         = {br, brT};
    #1;
    obsReq   = inst_sram_req;
    obsValid = if_id_valid;
    obsBus   = if_id_bus;
    obsAddr  = inst_sram_addr;
    redirect = wb | er | br;
    if (!rstn) begin
      checkOutput("reqInReset", 65'(obsReq), 65'd0);
      checkOutput("validInReset", 65'(obsValid), 65'd0);
      expQ.delete();
      expPc = RESET_PC;
    end else begin
      if (wb || er) checkOutput("validOnFlush", 65'(obsValid), 65'd0);
      if (redirect) checkOutput("reqOnRedirect", 65'(obsReq), 65'd0);
      if (obsReq) checkOutput("fetchAddr", 65'(obsAddr), 65'({expPc[31:2], 2'b00}));
`ifdef IF_ADEF_EN
      if (!redirect && expPc[1:0] != 2'b00) checkOutput("adefNoReq", 65'(obsReq), 65'd0);
`endif
      if (obsValid && allow && !redirect) begin
        expEntry = (expQ.size() != 0) ? expQ.pop_front() : {BW{1'b1}};
        checkOutput("entry", 65'(obsBus), 65'(expEntry));
      end
      if (redirect) begin
        tgt = wb ? wbT : (er ? erT : brT);
        expQ.delete();
        expPc = tgt;
`ifdef IF_ADEF_EN
        if (tgt[1:0] != 2'b00) expQ.push_back(mkEntry(1'b1, tgt, 32'h0));
`endif
      end else if (obsReq && aok) begin
        expQ.push_back(mkEntry(1'b0, {expPc[31:2], 2'b00}, instOf({expPc[31:2], 2'b00})));
        pending.push_back({expPc[31:2], 2'b00});
        expPc = expPc + 32'd4;
      end
    end
    if (inst_sram_data_ok) pending.delete(0);
  endtask

  task automatic step(input logic rstn, input logic aok, input logic dEn, input logic allow);
    applyStimulus(rstn, aok, dEn, allow, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Stop new fetches and let every in-flight and buffered entry reach ID
  task automatic drainAll();
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b1);
      if (pending.size() == 0 && expQ.size() == 0 && !obsValid) break;
    end
    checkOutput("drained", 65'(expQ.size()), 65'd0);
    checkOutput("noExtraEntry", 65'(obsValid), 65'd0);
  endtask

  initial begin
    resetn = 1'b0; id_allowin = 1'b0; id_if_bus = '0; wb_ex = 1'b0; ex_entry = '0;
    ertn_flush = 1'b0; ertn_entry = '0; inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0;
    inst_sram_rdata = '0; expPc = RESET_PC;

    // Reset and first-fetch latency
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("reqAfterReset", 65'(obsReq), 65'd0);
    checkOutput("validAfterReset", 65'(obsValid), 65'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("firstReq", 65'(obsReq), 65'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("validLatency", 65'(obsValid), 65'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("firstValid", 65'(obsValid), 65'd1);
    checkOutput("firstPc", 65'(obsBus[63:32]), 65'(RESET_PC));
    repeat (8) step(1'b1, 1'b1, 1'b1, 1'b1);

    // ID stalled: buffer fills to its depth and requests stop
    repeat (12) step(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("bufferedCount", 65'(expQ.size()), 65'd4);
    checkOutput("reqWhenFull", 65'(obsReq), 65'd0);
    checkOutput("validWhenFull", 65'(obsValid), 65'd1);
    drainAll();

    // Two outstanding at 1c000008/1c00000c, then a branch drops both responses
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("reqMaxOutst", 65'(obsReq), 65'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1c000100);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("addrAfterBranch", 65'(obsAddr), 65'h1c000100);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("validAfterBranch", 65'(obsValid), 65'd1);
    checkOutput("pcAfterBranch", 65'(obsBus[63:32]), 65'h1c000100);
    drainAll();

    // wb_ex and br_taken together: exception target wins, buffered entries hidden and lost
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1c008000, 1'b0, 32'h0, 1'b1, 32'h1c000200);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("addrAfterWbEx", 65'(obsAddr), 65'h1c008000);
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b1);
    // ertn outranks a same-cycle branch
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1c000040, 1'b1, 32'h1c000200);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("addrAfterErtn", 65'(obsAddr), 65'h1c000040);
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b1);
    drainAll();

    // Reset with two requests outstanding; their late responses must be ignored
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("validAfterMidReset", 65'(obsValid), 65'd0);
    checkOutput("reqAfterMidReset", 65'(obsReq), 65'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("restartAddr", 65'(obsAddr), 65'(RESET_PC));
    checkOutput("validLateData", 65'(obsValid), 65'd0);
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b1);
    drainAll();

`ifdef IF_ADEF_EN
    // Misaligned ertn target: one adef entry, no requests until the next redirect
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1c000102, 1'b0, 32'h0);
    repeat (5) step(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("adefReqHeld", 65'(obsReq), 65'd0);
    checkOutput("adefConsumed", 65'(expQ.size()), 65'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1c000000, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) step(1'b1, 1'b1, 1'b1, 1'b1);
    drainAll();
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
